// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if
// One Avalon-MM style link between a command issuer and a command acceptor.
// The arbiter uses three of these: one per master (arbiter on the slave
// side) and one towards the SDRAM controller (arbiter on the master side).
//
// Parameters: AW word address width, DW data width (byteenable is DW/8).
// Signals:
//   address, read, write, writedata, byteenable  command, issuer -> acceptor
//   waitrequest                                   stall, acceptor -> issuer
//   readdata, readdatavalid                       read response, acceptor -> issuer
interface sdram_arbiter_if #(
    parameter int AW = 24,
    parameter int DW = 32
);
    logic [AW-1:0]   address;
    logic            read;
    logic            write;
    logic [DW-1:0]   writedata;
    logic [DW/8-1:0] byteenable;
    logic            waitrequest;
    logic [DW-1:0]   readdata;
    logic            readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Two-master arbiter in front of a single SDRAM controller port. Commands are
// granted one at a time through an IDLE/CMD FSM; accepted reads record the
// issuing master in a tag FIFO so that in-order read data can be routed back.
//
// Parameters: AW address width, DW data width, PEND_DEPTH tag FIFO capacity
//             (power of 2, >= 2).
// Ports:
//   sys_clk, sys_rst  clock and asynchronous active-high reset
//   m0, m1            master links (arbiter is the slave side)
//   s                 link to the SDRAM controller (arbiter is the master side)
//   err_orphan        sticky: read data arrived with no read outstanding
//
// Configuration macro SDRAM_ARB_PRIO_EN: when defined, master 0 always wins a
// tie (fixed priority); when undefined, ties are broken round-robin.
module sdram_arbiter #(
    parameter int AW         = 24,
    parameter int DW         = 32,
    parameter int PEND_DEPTH = 4
) (
    input  logic sys_clk,
    input  logic sys_rst,
    sdram_arbiter_if.slave  m0,
    sdram_arbiter_if.slave  m1,
    sdram_arbiter_if.master s,
    output logic err_orphan
);
    localparam int PW = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(PEND_DEPTH);

    typedef enum logic {IDLE, CMD} state_t;

    state_t          state, state_nx;
    logic            gnt, gnt_nx;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic [PEND_DEPTH-1:0] tag_mem;

    logic            full, empty;
    logic            elig0, elig1, any_elig, sel;
    logic            cmd_rd, cmd_wr, accept, push, pop, head;
    logic [AW-1:0]   addr_mux;
    logic [DW-1:0]   wdata_mux;
    logic [DW/8-1:0] be_mux;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    // A read is only worth granting if its tag has somewhere to go.
    assign elig0    = m0.write | (m0.read & ~full);
    assign elig1    = m1.write | (m1.read & ~full);
    assign any_elig = elig0 | elig1;

`ifdef SDRAM_ARB_PRIO_EN
    assign sel = ~elig0;
`else
    logic last;

    // The master that did not win last time takes a tie.
    assign sel = (elig0 & elig1) ? ~last : elig1;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            last <= 1'b1;
        else if (state == IDLE && any_elig)
            last <= sel;
    end
`endif

    assign addr_mux  = gnt ? m1.address    : m0.address;
    assign wdata_mux = gnt ? m1.writedata  : m0.writedata;
    assign be_mux    = gnt ? m1.byteenable : m0.byteenable;

    assign s.address    = addr_mux;
    assign s.writedata  = wdata_mux;
    assign s.byteenable = be_mux;
    assign s.read       = cmd_rd;
    assign s.write      = cmd_wr;

    assign head = tag_mem[rd_ptr];
    assign pop  = s.readdatavalid & ~empty;

    assign m0.readdata      = s.readdata;
    assign m1.readdata      = s.readdata;
    assign m0.readdatavalid = pop & ~head;
    assign m1.readdatavalid = pop & head;

    always_comb begin
        state_nx       = state;
        gnt_nx         = gnt;
        cmd_rd         = 1'b0;
        cmd_wr         = 1'b0;
        m0.waitrequest = 1'b1;
        m1.waitrequest = 1'b1;
        accept         = 1'b0;
        push           = 1'b0;
        case (state)
            IDLE: begin
                if (any_elig) begin
                    state_nx = CMD;
                    gnt_nx   = sel;
                end
            end
            CMD: begin
                cmd_rd = gnt ? m1.read  : m0.read;
                cmd_wr = gnt ? m1.write : m0.write;
                if (gnt)
                    m1.waitrequest = s.waitrequest;
                else
                    m0.waitrequest = s.waitrequest;
                accept = (cmd_rd | cmd_wr) & ~s.waitrequest;
                // A master granted for a write that turns into a read while the
                // FIFO is full would overflow it; such a tag is not stored.
                push   = accept & cmd_rd & (~full | pop);
                // Leave on acceptance, or when the master withdraws its command.
                if (accept || !(cmd_rd || cmd_wr))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
            gnt   <= 1'b0;
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
        end
    end

    // Pointers wrap naturally because PEND_DEPTH is a power of 2.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
            if (s.readdatavalid && empty)
                err_orphan <= 1'b1;
        end
    end

    // Tag storage needs no reset: entries outside the count are never read.
    always_ff @(posedge sys_clk) begin
        if (push)
            tag_mem[wr_ptr] <= gnt;
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
// Directed bench for sdram_arbiter. Master drivers hold each queued command
// until it is accepted; a negedge monitor compares every accepted slave
// command and every routed read response against expected queues.
module tb_sdram_arbiter;
    localparam int AW = 24;
    localparam int DW = 32;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct {
        bit            m;
        logic [DW-1:0] data;
    } rsp_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic err_orphan;

    cmd_t mq[2][$];
    cmd_t exp_cmd[$];
    rsp_t exp_rsp[$];
    cmd_t mon_c;
    rsp_t mon_r;

    int checks = 0;
    int passes = 0;

    sdram_arbiter_if #(.AW(AW), .DW(DW)) m0_bus ();
    sdram_arbiter_if #(.AW(AW), .DW(DW)) m1_bus ();
    sdram_arbiter_if #(.AW(AW), .DW(DW)) s_bus ();

    sdram_arbiter #(.AW(AW), .DW(DW), .PEND_DEPTH(4)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .m0         (m0_bus),
        .m1         (m1_bus),
        .s          (s_bus),
        .err_orphan (err_orphan)
    );

    always #5 sys_clk = ~sys_clk;

    // Master drivers: update at posedge+1, sample acceptance just before the edge.
    for (genvar g = 0; g < 2; g++) begin : drv
        logic          rd, wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          wt;

        if (g == 0) begin : c0
            assign m0_bus.read       = rd;
            assign m0_bus.write      = wr;
            assign m0_bus.address    = addr;
            assign m0_bus.writedata  = wdata;
            assign m0_bus.byteenable = 4'hF;
            assign wt                = m0_bus.waitrequest;
        end else begin : c1
            assign m1_bus.read       = rd;
            assign m1_bus.write      = wr;
            assign m1_bus.address    = addr;
            assign m1_bus.writedata  = wdata;
            assign m1_bus.byteenable = 4'hF;
            assign wt                = m1_bus.waitrequest;
        end

        initial begin
            bit   busy;
            bit   acc;
            cmd_t c;
            busy  = 1'b0;
            acc   = 1'b0;
            rd    = 1'b0;
            wr    = 1'b0;
            addr  = '0;
            wdata = '0;
            forever begin
                @(posedge sys_clk);
                #1;
                if (acc) begin
                    busy = 1'b0;
                    rd   = 1'b0;
                    wr   = 1'b0;
                end
                if (!busy && mq[g].size() > 0) begin
                    c     = mq[g].pop_front();
                    rd    = !c.wr;
                    wr    = c.wr;
                    addr  = c.addr;
                    wdata = c.data;
                    busy  = 1'b1;
                end
                #7;
                acc = busy && !wt;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv)
            passes++;
        else
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
    endtask

    task automatic reportFail(input string name, input string detail);
        checks++;
        $display("[TB] FAIL %s %s", name, detail);
    endtask

    task automatic applyStimulus(input int m, input bit wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data);
        cmd_t c;
        c.wr   = wr;
        c.addr = addr;
        c.data = data;
        mq[m].push_back(c);
    endtask

    task automatic expectCmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        cmd_t c;
        c.wr   = wr;
        c.addr = addr;
        c.data = data;
        exp_cmd.push_back(c);
    endtask

    task automatic expectRsp(input bit m, input logic [DW-1:0] data);
        rsp_t r;
        r.m    = m;
        r.data = data;
        exp_rsp.push_back(r);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic waitCmdDrain(input int budget);
        int n = 0;
        while (exp_cmd.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_cmd.size() > 0) begin
            reportFail("cmd_timeout", $sformatf("actual=%0d_pending required=0", exp_cmd.size()));
            exp_cmd.delete();
        end
        tick();
    endtask

    task automatic waitIssue(input logic [AW-1:0] addr, input int budget);
        int n = 0;
        while (!(s_bus.read && s_bus.address == addr) && n < budget) begin
            tick();
            n++;
        end
        if (n == budget)
            reportFail("issue_timeout", $sformatf("actual=not_issued required=addr_%0h", addr));
    endtask

    task automatic sendResp(input logic [DW-1:0] data);
        s_bus.readdata      = data;
        s_bus.readdatavalid = 1'b1;
        tick();
        s_bus.readdatavalid = 1'b0;
    endtask

    // Monitor: compares accepted commands and routed responses mid-cycle.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if ((s_bus.read || s_bus.write) && !s_bus.waitrequest) begin
                if (exp_cmd.size() == 0) begin
                    reportFail("unexpected_cmd", $sformatf("actual=addr_%0h required=none", s_bus.address));
                end else begin
                    mon_c = exp_cmd.pop_front();
                    checkOutput("cmd_write", 64'(s_bus.write), 64'(mon_c.wr));
                    checkOutput("cmd_addr", 64'(s_bus.address), 64'(mon_c.addr));
                    if (mon_c.wr)
                        checkOutput("cmd_wdata", 64'(s_bus.writedata), 64'(mon_c.data));
                end
            end
            if (m0_bus.readdatavalid || m1_bus.readdatavalid) begin
                if (exp_rsp.size() == 0) begin
                    reportFail("unexpected_rsp",
                               $sformatf("actual=rdv_%0b%0b required=none", m1_bus.readdatavalid, m0_bus.readdatavalid));
                end else begin
                    mon_r = exp_rsp.pop_front();
                    checkOutput("rsp_route", {62'd0, m1_bus.readdatavalid, m0_bus.readdatavalid},
                                mon_r.m ? 64'd2 : 64'd1);
                    checkOutput("rsp_data", 64'(mon_r.m ? m1_bus.readdata : m0_bus.readdata), 64'(mon_r.data));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        s_bus.waitrequest   = 1'b0;
        s_bus.readdata      = '0;
        s_bus.readdatavalid = 1'b0;
        sys_rst             = 1'b1;
        tick();
        tick();
        checkOutput("reset_s_read", 64'(s_bus.read), 64'd0);
        checkOutput("reset_s_write", 64'(s_bus.write), 64'd0);
        checkOutput("reset_m0_wait", 64'(m0_bus.waitrequest), 64'd1);
        checkOutput("reset_m1_wait", 64'(m1_bus.waitrequest), 64'd1);
        checkOutput("reset_rdv", {62'd0, m1_bus.readdatavalid, m0_bus.readdatavalid}, 64'd0);
        checkOutput("reset_orphan", 64'(err_orphan), 64'd0);
        sys_rst = 1'b0;
        tick();

        $display("[TB] both masters read back to back");
        applyStimulus(0, 1'b0, 24'h10, 32'h0);
        applyStimulus(0, 1'b0, 24'h11, 32'h0);
        applyStimulus(1, 1'b0, 24'h20, 32'h0);
        applyStimulus(1, 1'b0, 24'h21, 32'h0);
`ifdef SDRAM_ARB_PRIO_EN
        expectCmd(1'b0, 24'h10, 32'h0);
        expectCmd(1'b0, 24'h11, 32'h0);
        expectCmd(1'b0, 24'h20, 32'h0);
        expectCmd(1'b0, 24'h21, 32'h0);
        waitCmdDrain(40);
        expectRsp(1'b0, 32'hA0); expectRsp(1'b0, 32'hA1);
        expectRsp(1'b1, 32'hA2); expectRsp(1'b1, 32'hA3);
`else
        expectCmd(1'b0, 24'h10, 32'h0);
        expectCmd(1'b0, 24'h20, 32'h0);
        expectCmd(1'b0, 24'h11, 32'h0);
        expectCmd(1'b0, 24'h21, 32'h0);
        waitCmdDrain(40);
        expectRsp(1'b0, 32'hA0); expectRsp(1'b1, 32'hA1);
        expectRsp(1'b0, 32'hA2); expectRsp(1'b1, 32'hA3);
`endif
        sendResp(32'hA0);
        sendResp(32'hA1);
        sendResp(32'hA2);
        sendResp(32'hA3);
        tick();

        $display("[TB] slave stall with m1 granted");
        s_bus.waitrequest = 1'b1;
        applyStimulus(1, 1'b0, 24'h30, 32'h0);
        expectCmd(1'b0, 24'h30, 32'h0);
        expectCmd(1'b0, 24'h31, 32'h0);
        waitIssue(24'h30, 20);
        applyStimulus(0, 1'b0, 24'h31, 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0)
                tick();
            checkOutput("stall_read", 64'(s_bus.read), 64'd1);
            checkOutput("stall_addr", 64'(s_bus.address), 64'h30);
            checkOutput("stall_m0_wait", 64'(m0_bus.waitrequest), 64'd1);
            checkOutput("stall_m1_wait", 64'(m1_bus.waitrequest), 64'd1);
        end
        tick();
        s_bus.waitrequest = 1'b0;
        waitCmdDrain(20);
        expectRsp(1'b1, 32'hB0);
        expectRsp(1'b0, 32'hB1);
        sendResp(32'hB0);
        sendResp(32'hB1);
        tick();

        $display("[TB] tag FIFO fill, write bypass, simultaneous push and pop");
        applyStimulus(1, 1'b0, 24'h40, 32'h0); expectCmd(1'b0, 24'h40, 32'h0); waitCmdDrain(20);
        applyStimulus(0, 1'b0, 24'h41, 32'h0); expectCmd(1'b0, 24'h41, 32'h0); waitCmdDrain(20);
        applyStimulus(1, 1'b0, 24'h42, 32'h0); expectCmd(1'b0, 24'h42, 32'h0); waitCmdDrain(20);
        applyStimulus(0, 1'b0, 24'h43, 32'h0); expectCmd(1'b0, 24'h43, 32'h0); waitCmdDrain(20);
        applyStimulus(0, 1'b0, 24'h44, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("full_no_read", 64'(s_bus.read), 64'd0);
            checkOutput("full_m0_wait", 64'(m0_bus.waitrequest), 64'd1);
        end
        applyStimulus(1, 1'b1, 24'h50, 32'hCAFE0001);
        expectCmd(1'b1, 24'h50, 32'hCAFE0001);
        waitCmdDrain(20);
        expectCmd(1'b0, 24'h44, 32'h0);
        expectRsp(1'b1, 32'hC0);
        sendResp(32'hC0);
        waitCmdDrain(20);
        s_bus.waitrequest = 1'b1;
        applyStimulus(1, 1'b0, 24'h45, 32'h0);
        expectCmd(1'b0, 24'h45, 32'h0);
        tick();
        tick();
        checkOutput("full_no_grant_f", 64'(s_bus.read), 64'd0);
        expectRsp(1'b0, 32'hC1);
        sendResp(32'hC1);
        waitIssue(24'h45, 20);
        expectRsp(1'b1, 32'hC2);
        s_bus.waitrequest   = 1'b0;
        s_bus.readdata      = 32'hC2;
        s_bus.readdatavalid = 1'b1;
        tick();
        s_bus.readdatavalid = 1'b0;
        applyStimulus(0, 1'b0, 24'h46, 32'h0);
        expectCmd(1'b0, 24'h46, 32'h0);
        waitCmdDrain(20);
        applyStimulus(0, 1'b0, 24'h47, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("refull_no_read", 64'(s_bus.read), 64'd0);
        end
        expectCmd(1'b0, 24'h47, 32'h0);
        expectRsp(1'b0, 32'hC3);
        sendResp(32'hC3);
        waitCmdDrain(20);
        expectRsp(1'b0, 32'hC4);
        expectRsp(1'b1, 32'hC5);
        expectRsp(1'b0, 32'hC6);
        expectRsp(1'b0, 32'hC7);
        sendResp(32'hC4);
        sendResp(32'hC5);
        sendResp(32'hC6);
        sendResp(32'hC7);
        tick();

        $display("[TB] orphan response");
        checkOutput("orphan_before", 64'(err_orphan), 64'd0);
        s_bus.readdata      = 32'hDEAD;
        s_bus.readdatavalid = 1'b1;
        #1;
        checkOutput("orphan_no_rdv", {62'd0, m1_bus.readdatavalid, m0_bus.readdatavalid}, 64'd0);
        tick();
        s_bus.readdatavalid = 1'b0;
        checkOutput("orphan_set", 64'(err_orphan), 64'd1);
        repeat (3) tick();
        checkOutput("orphan_sticky", 64'(err_orphan), 64'd1);
        sys_rst = 1'b1;
        #1;
        checkOutput("orphan_reset", 64'(err_orphan), 64'd0);
        tick();
        sys_rst = 1'b0;
        tick();

        $display("[TB] reset with a read outstanding and a command in flight");
        applyStimulus(0, 1'b0, 24'h60, 32'h0);
        expectCmd(1'b0, 24'h60, 32'h0);
        waitCmdDrain(20);
        s_bus.waitrequest = 1'b1;
        applyStimulus(1, 1'b0, 24'h61, 32'h0);
        expectCmd(1'b0, 24'h61, 32'h0);
        waitIssue(24'h61, 20);
        sys_rst = 1'b1;
        #1;
        checkOutput("midrst_s_read", 64'(s_bus.read), 64'd0);
        checkOutput("midrst_m0_wait", 64'(m0_bus.waitrequest), 64'd1);
        checkOutput("midrst_m1_wait", 64'(m1_bus.waitrequest), 64'd1);
        tick();
        tick();
        sys_rst = 1'b0;
        waitIssue(24'h61, 20);
        sendResp(32'hE0);
        checkOutput("post_rst_orphan", 64'(err_orphan), 64'd1);
        s_bus.waitrequest = 1'b0;
        waitCmdDrain(20);
        expectRsp(1'b1, 32'hE1);
        sendResp(32'hE1);
        tick();

        checkOutput("cmd_all_seen", 64'(exp_cmd.size()), 64'd0);
        checkOutput("rsp_all_seen", 64'(exp_rsp.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter AW, default 24: word address width of both masters and the slave port.
REQ-002 Parameter DW, default 32: data width; byteenable width is DW/8.
REQ-003 Parameter PEND_DEPTH, default 4: capacity of the outstanding-read tag FIFO (power of 2, at least 2).
REQ-004 Ports: sys_clk in 1, the single clock; sys_rst in 1, asynchronous active-high reset.
REQ-005 Ports: m0_address in AW, m0_read in 1, m0_write in 1, m0_writedata in DW, m0_byteenable in DW/8 (master 0 command).
REQ-006 Ports: m0_waitrequest out 1, m0_readdata out DW, m0_readdatavalid out 1 (master 0 response).
REQ-007 Ports: m1_address, m1_read, m1_write, m1_writedata, m1_byteenable, m1_waitrequest, m1_readdata, m1_readdatavalid: same widths and meanings for master 1.
REQ-008 Ports: s_address out AW, s_read out 1, s_write out 1, s_writedata out DW, s_byteenable out DW/8 (command to the SDRAM controller).
REQ-009 Ports: s_waitrequest in 1, s_readdata in DW, s_readdatavalid in 1 (response from the SDRAM controller).
REQ-010 Ports: err_orphan out 1: sticky flag, set when read data arrives with no read outstanding.

Function
REQ-011 The arbiter SHALL use a two-state FSM, IDLE and CMD, with a grant register gnt in {0,1}.
REQ-012 In IDLE: a master is eligible if write=1, or if read=1 and the tag FIFO is not full; if any master is eligible, the arbiter SHALL load gnt and enter CMD on the next edge.
REQ-013 In IDLE: all s_read/s_write SHALL be 0 and both m*_waitrequest SHALL be 1.
REQ-014 In CMD: s_* command signals SHALL combinationally equal the granted master's; m[gnt]_waitrequest = s_waitrequest; the other master's waitrequest = 1.
REQ-015 In CMD: the command is accepted when (s_read|s_write)=1 and s_waitrequest=0; on acceptance the FSM SHALL return to IDLE, and an accepted read SHALL push gnt into the tag FIFO in that cycle.
REQ-016 In CMD: if the granted master deasserts both read and write before acceptance, the FSM SHALL return to IDLE with no push.
REQ-017 Minimum throughput: one command per 2 cycles; grant latency from request to s_read/s_write asserted is 1 cycle.
REQ-018 On s_readdatavalid=1 with the FIFO non-empty, the arbiter SHALL pop the head tag; m[tag]_readdatavalid=1 in the same cycle, the other =0; both m*_readdata = s_readdata at all times.
REQ-019 A push and a pop in the same cycle SHALL both take effect, leaving the FIFO count unchanged; this is legal even when the FIFO is full.
REQ-020 With the FIFO full: reads SHALL not be granted; writes SHALL remain grantable.
REQ-021 On s_readdatavalid=1 with the FIFO empty: data SHALL be dropped (no m*_readdatavalid) and err_orphan SHALL set, cleared only by reset.
REQ-022 Round-robin: a last pointer records the master most recently granted; when both are eligible, the master != last SHALL win; last updates on every grant.
REQ-023 FIFO pointers SHALL wrap modulo PEND_DEPTH; count SHALL range 0..PEND_DEPTH.

Reset
REQ-024 While sys_rst=1, asynchronously: state=IDLE, gnt=0, last=1 (master 0 wins first tie), FIFO empty, err_orphan=0.
REQ-025 Outputs during reset: s_read=s_write=0, m*_waitrequest=1, m*_readdatavalid=0.
REQ-026 Reset asserted mid-command or with reads outstanding SHALL discard all tags; responses arriving after reset release SHALL flag err_orphan.

Configuration
REQ-027 Macro SDRAM_ARB_PRIO_EN defined: fixed priority; master 0 always wins when both masters are eligible, and last is unused.
REQ-028 Macro SDRAM_ARB_PRIO_EN undefined: round-robin per REQ-022.

Verification
REQ-029 Both masters read continuously after reset, in round-robin mode -> grants alternate 0,1,0,1; each readdatavalid is routed to its issuer in order.
REQ-030 s_waitrequest held at 1 for 5 cycles with m1 granted -> s_address stable and m0_waitrequest=1 throughout; accepted on cycle 6; no double push.
REQ-031 PEND_DEPTH=4, 4 reads accepted with no response -> a 5th read is not granted; a write from m1 is granted and issued; one s_readdatavalid -> the 5th read is then granted.
REQ-032 Accept and s_readdatavalid in the same cycle while the FIFO is full -> count stays 4 and routing is correct.
REQ-033 s_readdatavalid pulse with the FIFO empty -> no m*_readdatavalid, err_orphan=1 until sys_rst.
REQ-034 SDRAM_ARB_PRIO_EN defined, both masters requesting continuously -> m0 is granted every time and m1 is starved.
